// File: rtl/frame_pattern_gen_pkg.sv
// Shared constants for the frame pattern generator: default 640x480@60
// timing, counter width, FSM state encoding and a gray-to-RGB helper.
package frame_pattern_gen_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Wide enough for any practical line or frame total (up to 4095).
  localparam int CNT_W = 12;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic logic [23:0] gray_rgb(input logic [7:0] level);
    return {level, level, level};
  endfunction

endpackage

// File: rtl/frame_pattern_gen_video_timing.sv
// Raster counters: hcnt/vcnt, active-area flag, raw (active-high) sync
// regions and a strobe on the last pixel of the frame.
module video_timing
  import frame_pattern_gen_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             clk,
  input  logic             resetn,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output logic             active,
  output logic             hsync_raw,
  output logic             vsync_raw,
  output logic             frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic line_end;

  assign line_end  = (hcnt == H_LAST);
  assign frame_end = line_end && (vcnt == V_LAST);
  assign active    = (hcnt < H_ACT) && (vcnt < V_ACT);
  assign hsync_raw = (hcnt >= HS_BEG) && (hcnt < HS_END);
  assign vsync_raw = (vcnt >= VS_BEG) && (vcnt < VS_END);

  // Pixel and line counters; vcnt advances once per completed line.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked branch and
    // all state uses non-blocking assignment to avoid read/write races.
    if (!resetn) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (line_end) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

endmodule

// File: rtl/frame_pattern_gen.sv
// Full-frame gray pattern generator. The requested level and enable are
// latched once per frame so a frame is never torn; outputs are registered.
module frame_pattern_gen
  import frame_pattern_gen_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pixel_frame_index,
  input  logic        loop_en,
  input  logic [31:0] colordef,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [23:0] rgb,
  output logic        frame_switch,
  output logic [15:0] frame_count
);

  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] vcnt;
  logic             active;
  logic             hsync_raw;
  logic             vsync_raw;
  logic             frame_end;
  logic             frame_start;

  logic [0:0]       state;
  logic             shown_en;
  logic             shown_level;
  logic             prev_en;
  logic             prev_level;
  logic [7:0]       level_sel;
  logic             unused_colordef;

  video_timing #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .clk       (clk),
    .resetn    (resetn),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .active    (active),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw),
    .frame_end (frame_end)
  );

  assign frame_start     = (hcnt == '0) && (vcnt == '0);
  assign shown_en        = (state == ST_RUN);
  assign level_sel       = shown_level ? colordef[15:8] : colordef[7:0];
  assign unused_colordef = ^colordef[31:16];

  // IDLE/RUN FSM plus per-frame level latch; only moves on the last pixel.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      shown_level <= 1'b0;
      prev_en     <= 1'b0;
      prev_level  <= 1'b0;
    end else if (frame_end) begin
      prev_en     <= shown_en;
      prev_level  <= shown_level;
      shown_level <= pixel_frame_index;
      case (state)
        ST_IDLE: if (loop_en)  state <= ST_RUN;
        ST_RUN:  if (!loop_en) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Registered video outputs, one cycle behind the raster counters.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hsync        <= ~SYNC_POL;
      vsync        <= ~SYNC_POL;
      de           <= 1'b0;
      rgb          <= '0;
      frame_switch <= 1'b0;
    end else begin
      hsync        <= hsync_raw ? SYNC_POL : ~SYNC_POL;
      vsync        <= vsync_raw ? SYNC_POL : ~SYNC_POL;
      de           <= active;
      rgb          <= (active && shown_en) ? gray_rgb(level_sel) : '0;
      frame_switch <= frame_start && shown_en && prev_en &&
                      (shown_level != prev_level);
    end
  end

  // Completed-frame counter, free-running modulo 2^16.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      frame_count <= '0;
    end else if (frame_end) begin
      frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: doc/frame_pattern_gen.md
FRAME_PATTERN_GEN -- requirements
Module: frame_pattern_gen

Interface
REQ-001 SHALL expose parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 SHALL expose parameters H_FP, H_SYNC, H_BP, 16/96/48, horizontal porch and sync widths in pixels.
REQ-003 SHALL expose parameter V_ACTIVE, 480, visible lines per frame.
REQ-004 SHALL expose parameters V_FP, V_SYNC, V_BP, 10/2/33, vertical porch and sync widths in lines.
REQ-005 SHALL expose parameter SYNC_POL, 0, sync asserted level (0 = active-low).
REQ-006 SHALL have port clk input 1, pixel clock; the only clock.
REQ-007 SHALL have port resetn input 1, reset; synchronous and active-low.
REQ-008 SHALL have port pixel_frame_index input 1, requested displayed level (1 = bright, 0 = dark).
REQ-009 SHALL have port loop_en input 1, pattern enable; low forces black output.
REQ-010 SHALL have port colordef input 32, [7:0] dark gray level, [15:8] bright gray level, [31:16] unused.
REQ-011 SHALL have ports hsync, vsync, de output 1, registered video timing.
REQ-012 SHALL have port rgb output 24, registered pixel, {R,G,B} all equal to the selected gray level.
REQ-013 SHALL have port frame_switch output 1, one-cycle pulse on the first active pixel of a frame whose level differs from the previous frame.
REQ-014 SHALL have port frame_count output 16, frames completed since reset.

Function
REQ-015 SHALL run hcnt 0..H_TOTAL-1 and vcnt 0..V_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise; hcnt wraps to 0 and vcnt advances on hcnt = H_TOTAL-1; vcnt wraps to 0 after V_TOTAL-1.
REQ-016 SHALL define active as hcnt < H_ACTIVE and vcnt < V_ACTIVE; hsync asserted for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC; vsync analogous on vcnt.
REQ-017 SHALL register all outputs: hsync/vsync/de/rgb/frame_switch reflect the counter values of the previous cycle (latency 1).
REQ-018 SHALL sample pixel_frame_index and loop_en into shown_level/shown_en only on the cycle hcnt = H_TOTAL-1 and vcnt = V_TOTAL-1; both are held constant for the entire following frame (no tearing).
REQ-019 SHALL output rgb = gray level colordef[15:8] (shown_level = 1) or colordef[7:0] (shown_level = 0) when de and shown_en; rgb = 0 whenever de = 0 or shown_en = 0.
REQ-020 SHALL read colordef combinationally per pixel; a mid-frame colordef change takes effect on the next pixel.
REQ-021 SHALL pulse frame_switch with the first active pixel (hcnt = 0, vcnt = 0) only when shown_en = 1 and shown_level differs from the level of the previous frame; no pulse on the first enabled frame after loop_en rises.
REQ-022 SHALL increment frame_count at each vcnt wrap, wrapping 0xFFFF -> 0.
REQ-023 SHALL treat pixel_frame_index toggles faster than one frame as: only the value at the sample cycle is shown; intermediate toggles are lost.
REQ-024 SHALL be implemented as FSM IDLE/RUN: IDLE while shown_en = 0 (black, no frame_switch); IDLE -> RUN at sample cycle with loop_en = 1; RUN -> IDLE at sample cycle with loop_en = 0.

Reset
REQ-025 SHALL on resetn = 0 at a clk edge set hcnt = vcnt = 0, state IDLE, shown_level = 0, shown_en = 0, frame_count = 0.
REQ-026 SHALL on reset drive de = 0, rgb = 0, frame_switch = 0, hsync = vsync = ~SYNC_POL.
REQ-027 SHALL, on reset asserted mid-frame, abandon the frame and restart timing at hcnt = vcnt = 0 on the first cycle after release.

Structure
REQ-028 SHALL place default timing constants and the IDLE/RUN state encoding in a shared package.
REQ-029 SHALL contain one sub-module video_timing (hcnt/vcnt, active, hsync/vsync raw, end-of-frame strobe).

Verification (H_ACTIVE=4, H_FP=H_SYNC=H_BP=1, V_ACTIVE=3, V_FP=V_SYNC=V_BP=1)
REQ-030 SHALL cover: reset release -> de first high 1 cycle after hcnt=0, 4 cycles high per line, hsync low exactly 1 of every 7 cycles, vsync low 7 cycles per 42-cycle frame.
REQ-031 SHALL cover: loop_en=1, index=1, colordef=0x0000_C010 -> next frame all active rgb=0xC0C0C0, blanking rgb=0.
REQ-032 SHALL cover: index 1->0 mid-frame -> current frame stays 0xC0C0C0, next frame 0x101010, frame_switch single pulse with its first pixel.
REQ-033 SHALL cover: index pulsed high for 5 cycles away from sample cycle -> no level change, no frame_switch.
REQ-034 SHALL cover: resetn low 3 cycles mid-line -> outputs at reset values, frame_count=0, timing restarts at hcnt=vcnt=0.
REQ-035 SHALL cover: frame_count preset run of 65536 frames -> wraps to 0.
